// File: rtl/stat_resp_misr.sv
// -----------------------------------------------------------------------------
// stat_resp_misr
//
// Purpose:
//   Response compactor for the Stat_* combinational benchmarks. Each accepted
//   benchmark output vector is folded into a multiple-input signature register
//   (MISR). After the programmed number of patterns the signature is compared
//   against a golden value, so a whole benchmark run collapses into one
//   pass/fail bit.
//
// Optional feature (compile-time macro):
//   STAT_MISR_XMASK_EN - adds input resp_mask. Each accepted response becomes
//                        resp_data & ~resp_mask before compaction, so unknown
//                        or don't-care outputs are forced to zero.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   begin a run (honoured in IDLE or DONE only)
//   num_patterns  in   COUNT_W  patterns to compact, latched on start
//   golden        in   WIDTH    expected signature, latched on start
//   resp_valid    in   resp_data holds a benchmark response
//   resp_ready    out  a response is accepted this cycle (RUN state)
//   resp_data     in   WIDTH    benchmark output vector (bit 0 = first output)
//   resp_mask     in   WIDTH    don't-care mask (STAT_MISR_XMASK_EN only)
//   busy          out  run in progress (RUN or CHECK)
//   done          out  run complete, pass is valid
//   pass          out  signature matched golden
//   signature     out  WIDTH    current MISR contents
//   pat_count     out  COUNT_W  responses accepted in the current run
// -----------------------------------------------------------------------------
module stat_resp_misr #(
   parameter int          WIDTH   = 32,
   parameter int          COUNT_W = 16,
   parameter logic [31:0] POLY    = 32'h04C11DB7,
   parameter logic [31:0] SEED    = 32'hFFFFFFFF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] num_patterns,
   input  logic [WIDTH-1:0]   golden,
   input  logic               resp_valid,
   output logic               resp_ready,
   input  logic [WIDTH-1:0]   resp_data,
`ifdef STAT_MISR_XMASK_EN
   input  logic [WIDTH-1:0]   resp_mask,
`endif
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [WIDTH-1:0]   signature,
   output logic [COUNT_W-1:0] pat_count
);

   localparam logic [WIDTH-1:0] POLY_L = POLY[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_L = SEED[WIDTH-1:0];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic               start_acc;
   logic               accept;
   logic [COUNT_W-1:0] cnt_lat;
   logic [WIDTH-1:0]   golden_lat;
   logic [COUNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0]   resp_eff;

   // One MISR step: shift left, reduce by POLY when the MSB falls out,
   // then fold in the new response vector.
   function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                  input logic [WIDTH-1:0] din);
      logic [WIDTH-1:0] fb;
      fb = sig[WIDTH-1] ? POLY_L : '0;
      return {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
   endfunction

`ifdef STAT_MISR_XMASK_EN
   assign resp_eff = resp_data & ~resp_mask;
`else
   assign resp_eff = resp_data;
`endif

   assign cnt_inc = pat_count + COUNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and state-decoded outputs. resp_ready/busy/done depend on
   // the registered state only, never on resp_valid.
   always_comb begin
      state_nxt  = state;
      resp_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      start_acc  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = (num_patterns == '0) ? CHECK : RUN;
            end
         end
         RUN: begin
            resp_ready = 1'b1;
            busy       = 1'b1;
            if (resp_valid) begin
               accept = 1'b1;
               // The run ends exactly on the latched count; pat_count never
               // exceeds it, so the increment cannot wrap.
               if (cnt_inc == cnt_lat) begin
                  state_nxt = CHECK;
               end
            end
         end
         CHECK: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               start_acc = 1'b1;
               state_nxt = (num_patterns == '0) ? CHECK : RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Run parameters: plain data captured on start, no reset needed.
   always_ff @(posedge clk) begin
      if (start_acc) begin
         cnt_lat    <= num_patterns;
         golden_lat <= golden;
      end
   end

   // Signature, pattern counter and verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signature <= SEED_L;
         pat_count <= '0;
         pass      <= 1'b0;
      end else begin
         if (start_acc) begin
            signature <= SEED_L;
            pat_count <= '0;
            pass      <= 1'b0;
         end else if (accept) begin
            signature <= misr_step(signature, resp_eff);
            pat_count <= cnt_inc;
         end else if (state == CHECK) begin
            pass <= (signature == golden_lat);
         end
      end
   end

endmodule

// File: tb/tb_stat_resp_misr.sv
// -----------------------------------------------------------------------------
// tb_stat_resp_misr
//
// Scoreboard bench for stat_resp_misr. Each run pushes its expected final
// signature / pattern count / verdict when it is issued; a monitor pops and
// compares whenever done rises. Random runs use a reference model that
// computes the signature with plain integer arithmetic (doubling modulo 2^32
// with polynomial reduction).
// -----------------------------------------------------------------------------
module tb_stat_resp_misr;

   localparam int          W    = 32;
   localparam int          CW   = 16;
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] num_patterns;
   logic [W-1:0]  golden;
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  resp_data;
   logic [W-1:0]  resp_mask;
   logic          busy;
   logic          done;
   logic          pass;
   logic [W-1:0]  signature;
   logic [CW-1:0] pat_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string         name;
      logic [31:0]   sig;
      logic [CW-1:0] cnt;
      logic          pas;
   } exp_t;

   exp_t expq[$];

   always #5 clk = ~clk;

   stat_resp_misr #(
      .WIDTH   (W),
      .COUNT_W (CW),
      .POLY    (POLY),
      .SEED    (32'hFFFFFFFF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .num_patterns (num_patterns),
      .golden       (golden),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
`ifdef STAT_MISR_XMASK_EN
      .resp_mask    (resp_mask),
`endif
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .signature    (signature),
      .pat_count    (pat_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response actually compacted for a given data/mask pair.
   function automatic logic [31:0] eff(input logic [31:0] d, input logic [31:0] m);
`ifdef STAT_MISR_XMASK_EN
      return d & ~m;
`else
      return d | (m & 32'h0);
`endif
   endfunction

   // Reference: signature = seed doubled per pattern modulo the polynomial,
   // XOR each response, using integer arithmetic.
   function automatic logic [31:0] model(input logic [31:0] d[$]);
      longint unsigned s;
      s = 64'hFFFF_FFFF;
      foreach (d[i]) begin
         s = s * 2;
         if (s >= 64'h1_0000_0000) s = (s - 64'h1_0000_0000) ^ {32'h0, POLY};
         s = s ^ {32'h0, d[i]};
      end
      return s[31:0];
   endfunction

   // Monitor: compares the scoreboard head whenever done rises.
   logic done_q = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_q) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending run");
         end else begin
            e = expq.pop_front();
            chk({e.name, "_sig"},  signature, e.sig);
            chk({e.name, "_cnt"},  pat_count, e.cnt);
            chk({e.name, "_pass"}, pass, e.pas);
         end
      end
      done_q <= done;
   end

   task automatic do_start(input logic [CW-1:0] n, input logic [31:0] g);
      int t = 0;
      while (busy && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      if (busy) chk("start_wait_timeout", 1, 0);
      start        = 1'b1;
      num_patterns = n;
      golden       = g;
      @(posedge clk); #1;
      start        = 1'b0;
   endtask

   // Offers one response until it is accepted; returns #1 after the accept edge.
   task automatic send(input logic [31:0] d, input logic [31:0] m);
      logic r;
      int   t = 0;
      resp_valid = 1'b1;
      resp_data  = d;
      resp_mask  = m;
      do begin
         @(negedge clk);
         r = resp_ready;
         @(posedge clk); #1;
         t++;
      end while (!r && t < 200);
      resp_valid = 1'b0;
      if (!r) chk("send_timeout", 1, 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!done) chk("done_timeout", 0, 1);
      @(negedge clk); #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_sig"},   signature, 32'hFFFFFFFF);
      chk({tag, "_cnt"},   pat_count, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_pass"},  pass, 0);
      chk({tag, "_ready"}, resp_ready, 0);
      chk({tag, "_busy"},  busy, 0);
   endtask

   // Random run with random data, masks and stalls.
   task automatic rand_run(input string name, input int n, input int max_stall);
      logic [31:0] dq[$];
      logic [31:0] mq[$];
      logic [31:0] eq[$];
      logic [31:0] s, g;
      exp_t        e;
      for (int i = 0; i < n; i++) begin
         dq.push_back($urandom);
         mq.push_back($urandom & $urandom);
         eq.push_back(eff(dq[i], mq[i]));
      end
      s = model(eq);
      g = ($urandom_range(1) == 1) ? s : $urandom;
      e.name = name; e.sig = s; e.cnt = CW'(n); e.pas = (g == s);
      expq.push_back(e);
      do_start(CW'(n), g);
      for (int i = 0; i < n; i++) begin
         idle_cycles($urandom_range(max_stall));
         send(dq[i], mq[i]);
      end
      wait_done();
   endtask

   initial begin
      exp_t        e;
      logic [31:0] bigq[$];
      logic [31:0] s;

      rst_n = 1'b0; start = 1'b0; num_patterns = '0; golden = '0;
      resp_valid = 1'b0; resp_data = '0; resp_mask = '0;
      idle_cycles(3);
      check_reset_vals("reset");
      rst_n = 1'b1;
      idle_cycles(2);

      // Single zero response; verdict exactly two cycles after the accept.
      e.name = "one_pat"; e.sig = 32'hFB3EE249; e.cnt = 1; e.pas = 1'b1;
      expq.push_back(e);
      do_start(1, 32'hFB3EE249);
      send(32'h0, 32'h0);
      chk("one_pat_check_busy", busy, 1);
      chk("one_pat_check_done", done, 0);
      @(posedge clk); #1;
      chk("one_pat_done_lat", done, 1);
      chk("one_pat_pass_lat", pass, 1);
      wait_done();

      // Two zero responses with a 3-cycle stall, wrong golden.
      e.name = "two_pat"; e.sig = 32'hF2BCD925; e.cnt = 2; e.pas = 1'b0;
      expq.push_back(e);
      do_start(2, 32'h0);
      send(32'h0, 32'h0);
      idle_cycles(3);
      chk("two_pat_stall_cnt", pat_count, 1);
      chk("two_pat_stall_sig", signature, 32'hFB3EE249);
      send(32'h0, 32'h0);
      wait_done();

      // Zero patterns: straight to CHECK, never ready.
      e.name = "zero_pat"; e.sig = 32'hFFFFFFFF; e.cnt = 0; e.pas = 1'b1;
      expq.push_back(e);
      resp_valid = 1'b1;
      do_start(0, 32'hFFFFFFFF);
      chk("zero_pat_ready0", resp_ready, 0);
      chk("zero_pat_busy",   busy, 1);
      @(posedge clk); #1;
      chk("zero_pat_ready1", resp_ready, 0);
      resp_valid = 1'b0;
      wait_done();

      // Asynchronous reset mid-run, then a clean 4-pattern run.
      do_start(4, 32'h0);
      send(32'h12345678, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      expq.delete();
      #1 rst_n = 1'b1;
      idle_cycles(2);
      rand_run("after_rst", 4, 2);

      // All-ones response with all-ones mask.
`ifdef STAT_MISR_XMASK_EN
      e.name = "mask_ones"; e.sig = 32'hFB3EE249;
`else
      e.name = "mask_ones"; e.sig = 32'h04C11DB6;
`endif
      e.cnt = 1; e.pas = 1'b0;
      expq.push_back(e);
      do_start(1, 32'h0);
      send(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done();

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         rand_run($sformatf("rand%0d", r), $urandom_range(1, 24), 3);
      end

      // Maximum count, back-to-back: the counter must stop at 16'hFFFF.
      for (int i = 0; i < 65535; i++) bigq.push_back($urandom);
      s = model(bigq);
      e.name = "max_cnt"; e.sig = s; e.cnt = 16'hFFFF; e.pas = 1'b1;
      expq.push_back(e);
      do_start(16'hFFFF, s);
      foreach (bigq[i]) send(bigq[i], 32'h0);
      wait_done();
      chk("max_cnt_hold", pat_count, 16'hFFFF);

      chk("scoreboard_empty", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
